// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared state, request record and constants for the LSU memory arbiter
package lsu_arb_pkg;
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 32;
  localparam logic [ARB_DATA_W-1:0] ERR_RDATA = '0;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef struct packed {
    logic                    wren;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   wdata;
    logic [ARB_DATA_W/8-1:0] bmask;
  } mem_req_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant with a last-winner pointer
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic last;
  // on a tie the requester that did not win last time gets the grant
  always_comb grant = !en ? 2'b00 : (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  // pointer remembers the winner; its reset value lets m0 take the first tie
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares one SRAM controller port between fetch (m0) and LSU (m1); ARB_TIMEOUT_EN adds a BUSY abort timer
module lsu_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_m0_req,
  input  logic                i_m0_wren,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_bmask,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  input  logic                i_m1_req,
  input  logic                i_m1_wren,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_bmask,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  output logic                o_mem_wren,
  output logic                o_mem_rden,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_ack,
  output logic                o_busy,
  output logic [1:0]          o_grant
);
  arb_state_e        state;
  mem_req_t          lat, req0, req1;
  logic [1:0]        owner, gnt;
  logic [DATA_W-1:0] rdata0, rdata1, cap;
  logic              done, err, expired;
  assign req0 = {i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_bmask};
  assign req1 = {i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_bmask};
  rr_arbiter_2 u_rr (
    .clk  (i_clk),
    .rst  (i_rst),
    .req  ({i_m1_req, i_m0_req}),
    .en   (state == IDLE),
    .grant(gnt)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign expired = (state == BUSY) && !i_mem_ack && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // counts BUSY cycles of the current transaction, zero whenever not BUSY
  always_ff @(posedge i_clk)
    if (i_rst || state != BUSY) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
`else
  assign expired = 1'b0;
`endif
  assign done = (state == BUSY) && (i_mem_ack || expired);
  assign cap  = expired ? ERR_RDATA : lat.wren ? '0 : i_mem_rdata;
  // grant latches the request, BUSY waits for ack or abort, RESP pulses the owner's ack
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state  <= IDLE;
      owner  <= '0;
      lat    <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          state <= BUSY;
          owner <= gnt;
          lat   <= gnt[1] ? req1 : req0;
          err   <= 1'b0;
        end
        BUSY: if (done) begin
          state <= RESP;
          err   <= expired;
          if (owner[0]) rdata0 <= cap;
          if (owner[1]) rdata1 <= cap;
        end
        default: begin
          state <= IDLE;
          owner <= '0;
        end
      endcase
    end
  assign o_busy      = state != IDLE;
  assign o_grant     = owner;
  assign o_mem_addr  = lat.addr;
  assign o_mem_wdata = lat.wdata;
  assign o_mem_bmask = lat.bmask;
  assign o_mem_wren  = (state == BUSY) && lat.wren;
  assign o_mem_rden  = (state == BUSY) && !lat.wren;
  assign o_m0_ack    = (state == RESP) && owner[0];
  assign o_m1_ack    = (state == RESP) && owner[1];
  assign o_m0_err    = o_m0_ack && err;
  assign o_m1_err    = o_m1_ack && err;
  assign o_m0_rdata  = rdata0;
  assign o_m1_rdata  = rdata1;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed stimulus with a scoreboard of expected acks checked by a monitor
module tb_lsu_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_wren = 1'b0, m1_req = 1'b0, m1_wren = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, mem_addr;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, mem_wdata;
  logic [3:0]    m0_bmask = '0, m1_bmask = '0, mem_bmask;
  logic          m0_ack, m0_err, m1_ack, m1_err, mem_wren, mem_rden, busy;
  logic [1:0]    grant;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t          q[$];
  exp_t          e_mon;
  int            n_pass = 0;
  int            n_total = 0;
  int            ctl_delay = 0;
  int            scnt = 0;
  int            n;
  logic [DW-1:0] ctl_rdata = '0;
  logic          stray = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_bmask(m0_bmask), .o_m0_rdata(m0_rdata), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_bmask(m1_bmask), .o_m1_rdata(m1_rdata), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .o_mem_rden(mem_rden), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_busy(busy), .o_grant(grant)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // controller model: acks ctl_delay strobe cycles after the strobe rises, 0 = never
  always @(negedge clk) begin
    if (stray) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      stray     = 1'b0;
    end else if ((mem_rden || mem_wren) && !mem_ack && ctl_delay != 0) begin
      scnt++;
      if (scnt == ctl_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = ctl_rdata + 32'(mem_addr);
      end
    end else begin
      mem_ack = 1'b0;
      scnt    = 0;
    end
  end

  // monitor: every ack pops one expectation
  always @(negedge clk)
    if (!rst && (m0_ack || m1_ack)) begin
      if (q.size() == 0) check("unexpected_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
      else begin
        e_mon = q.pop_front();
        check("ack_port", {62'd0, m1_ack, m0_ack}, e_mon.port ? 64'd2 : 64'd1);
        check("ack_rdata", e_mon.port ? m1_rdata : m0_rdata, e_mon.rdata);
        check("ack_err", e_mon.port ? m1_err : m0_err, e_mon.err);
        check("other_err", e_mon.port ? m0_err : m1_err, 0);
      end
    end

  task automatic wait_grant(input string nm, input logic [1:0] exp);
    int k = 0;
    do begin @(negedge clk); k++; end while (grant == 2'b00 && k < 50);
    check(nm, grant, exp);
  endtask

  task automatic next_grant(input string nm, input logic [1:0] exp);
    int k = 0;
    while (grant != 2'b00 && k < 50) begin @(negedge clk); k++; end
    wait_grant(nm, exp);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((busy || q.size() != 0) && k < 200) begin @(negedge clk); k++; end
    check(nm, k < 200, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_rden", mem_rden, 0);
    check("rst_acks", {m1_ack, m0_ack}, 0);
    check("rst_rdata", m0_rdata, 0);
    check("rst_addr", mem_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    // both request three times back to back: m0, m1, m0
    ctl_delay = 2; ctl_rdata = 32'hA000_0000;
    m0_addr = 16'h0100; m1_addr = 16'h0200;
    q.push_back('{port: 1'b0, rdata: 32'hA000_0100, err: 1'b0});
    q.push_back('{port: 1'b1, rdata: 32'hA000_0200, err: 1'b0});
    q.push_back('{port: 1'b0, rdata: 32'hA000_0100, err: 1'b0});
    m0_req = 1'b1; m1_req = 1'b1;
    wait_grant("t2_grant0", 2'b01);
    next_grant("t2_grant1", 2'b10);
    next_grant("t2_grant2", 2'b01);
    m0_req = 1'b0; m1_req = 1'b0;
    wait_drain("t2_drain");
    // m0 read, ack on the fourth strobe cycle
    ctl_delay = 4; ctl_rdata = 32'h1234_5668; m0_addr = 16'h0010;
    q.push_back('{port: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
    @(posedge clk); #1 m0_req = 1'b1;
    wait_grant("t1_grant", 2'b01);
    m0_req = 1'b0;
    check("t1_addr", mem_addr, 16'h0010);
    n = 0;
    while (mem_rden && n < 50) begin n++; @(negedge clk); end
    check("t1_rden_cycles", n, 4);
    wait_drain("t1_drain");
    check("t1_rdata_hold", m0_rdata, 32'h1234_5678);
    // m1 write with inputs disturbed during BUSY
    ctl_delay = 5; m1_wren = 1'b1; m1_addr = 16'h0020; m1_wdata = 32'hCAFE_F00D; m1_bmask = 4'b0011;
    q.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b0});
    @(posedge clk); #1 m1_req = 1'b1;
    wait_grant("t3_grant", 2'b10);
    m1_req = 1'b0; m1_addr = 16'hFFFF; m1_wdata = 32'h0BAD_0BAD; m1_bmask = 4'b1100; m1_wren = 1'b0;
    n = 0;
    while (mem_wren && n < 50) begin
      check("t3_addr", mem_addr, 16'h0020);
      check("t3_wdata", mem_wdata, 32'hCAFE_F00D);
      check("t3_bmask", mem_bmask, 4'b0011);
      check("t3_rden", mem_rden, 0);
      n++;
      @(negedge clk);
    end
    check("t3_wren_cycles", n, 5);
    wait_drain("t3_drain");
    // reset in the middle of a transaction
    ctl_delay = 0; m0_addr = 16'h0040;
    @(posedge clk); #1 m0_req = 1'b1;
    wait_grant("t4_grant", 2'b01);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_rden", mem_rden, 0);
    check("t4_grant", grant, 0);
    check("t4_ack", {m1_ack, m0_ack}, 0);
    @(posedge clk); #1 rst = 1'b0;
    ctl_delay = 1; ctl_rdata = 32'h5000_0000; m0_addr = 16'h0044; m1_addr = 16'h0048;
    q.push_back('{port: 1'b0, rdata: 32'h5000_0044, err: 1'b0});
    m0_req = 1'b1; m1_req = 1'b1;
    wait_grant("t4_regrant", 2'b01);
    m0_req = 1'b0; m1_req = 1'b0;
    wait_drain("t4_drain");
    // stray ack while idle
    @(posedge clk); #1 stray = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_grant", grant, 0);
    check("t6_rdata_hold", m0_rdata, 32'h5000_0044);
`ifdef ARB_TIMEOUT_EN
    // controller never acks: abort after 8 BUSY cycles
    ctl_delay = 0; m0_addr = 16'h0080;
    q.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b1});
    @(posedge clk); #1 m0_req = 1'b1;
    wait_grant("t5_grant", 2'b01);
    m0_req = 1'b0;
    n = 0;
    while (mem_rden && n < 50) begin n++; @(negedge clk); end
    check("t5_busy_cycles", n, 8);
    wait_drain("t5_drain");
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_stray_busy", busy, 0);
    check("t5_rdata", m0_rdata, 0);
`endif
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
